// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, letter-group tables and scan FSM encoding for the keypad front end
package keypad_pkg;

  typedef enum logic [7:0] {
    KEY_CLEAR      = 8'd9,
    KEY_SUB_LETTER = 8'd10,
    KEY_SUB_WORD   = 8'd11
  } key_cmd_e;

  localparam logic [7:0] NUM_GROUPS = 8'd9;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t ST_SCAN        = 2'd0;
  localparam scan_state_t ST_DEB_PRESS   = 2'd1;
  localparam scan_state_t ST_DEB_RELEASE = 2'd2;

  function automatic logic [7:0] group_base(input logic [3:0] grp);
    logic [7:0] b;
    case (grp)
      4'd0:    b = 8'h41;
      4'd1:    b = 8'h44;
      4'd2:    b = 8'h47;
      4'd3:    b = 8'h4A;
      4'd4:    b = 8'h4D;
      4'd5:    b = 8'h50;
      4'd6:    b = 8'h53;
      4'd7:    b = 8'h56;
      4'd8:    b = 8'h59;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // YZ is the only short group; everything else cycles through three letters.
  function automatic logic [1:0] group_size(input logic [3:0] grp);
    return (grp == 4'd8) ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row synchroniser, column scan and press/release debounce
// Emits a one-cycle key_vld with key_code = row*COLS+col per debounced press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic            key_vld,
  output logic [7:0]      key_code
);

  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [ROWS-1:0]  row_s1_q, row_sync_q;
  scan_state_t      state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [ROWS-1:0]  pat_q, pat_d;
  logic             key_vld_q, key_vld_d;
  logic [7:0]       key_code_q, key_code_d;

  function automatic logic [RW-1:0] lowest_row(input logic [ROWS-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) r = RW'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    pat_d      = pat_q;
    key_vld_d  = 1'b0;
    key_code_d = key_code_q;
    case (state_q)
      ST_SCAN: begin
        if (row_sync_q != '0) begin
          state_d = ST_DEB_PRESS;
          cnt_d   = '0;
          pat_d   = row_sync_q;
          row_d   = lowest_row(row_sync_q);
        end else if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        // Any deviation from the captured row pattern counts as bounce.
        if (row_sync_q != pat_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d    = ST_DEB_RELEASE;
          cnt_d      = '0;
          key_vld_d  = 1'b1;
          key_code_d = 8'(row_q) * 8'(COLS) + 8'(col_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEB_RELEASE: begin
        if (row_sync_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      row_s1_q   <= '0;
      row_sync_q <= '0;
      state_q    <= ST_SCAN;
      col_q      <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      pat_q      <= '0;
      key_vld_q  <= 1'b0;
      key_code_q <= '0;
    end else begin
      row_s1_q   <= row_in;
      row_sync_q <= row_s1_q;
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      pat_q      <= pat_d;
      key_vld_q  <= key_vld_d;
      key_code_q <= key_code_d;
    end
  end

  assign col_out  = COLS'(1) << col_q;
  assign key_vld  = key_vld_q;
  assign key_code = key_code_q;

endmodule

// File: rtl/keypad_word_entry.sv
// rtl/keypad_word_entry.sv - multi-tap letter selection and word assembly on top of the scanner
module keypad_word_entry
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int MAX_WORD_LEN    = 8
) (
  input  logic                                clk,
  input  logic                                nRst,
  input  logic [ROWS-1:0]                     row_in,
  output logic [COLS-1:0]                     col_out,
  output logic                                pending_vld,
  output logic [7:0]                          pending_chr,
  output logic                                commit_vld,
  output logic [7:0]                          commit_chr,
  output logic                                del_pulse,
  output logic                                word_done,
  output logic [$clog2(MAX_WORD_LEN+1)-1:0]   word_len,
  output logic                                key_error
);

  localparam int LEN_W = $clog2(MAX_WORD_LEN + 1);

  logic             key_vld;
  logic [7:0]       key_code;
  logic             pend_q, pend_d;
  logic [3:0]       group_q, group_d;
  logic [1:0]       tap_q, tap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       commit_chr_q, commit_chr_d;
  logic             commit_q, commit_d, del_q, del_d, done_q, done_d, err_q, err_d;
  logic [7:0]       pend_chr;

  keypad_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk      (clk),
    .nRst     (nRst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_vld  (key_vld),
    .key_code (key_code)
  );

  assign pend_chr = pend_q ? group_base(group_q) + {6'd0, tap_q} : 8'h00;

  always_comb begin
    pend_d       = pend_q;
    group_d      = group_q;
    tap_d        = tap_q;
    len_d        = len_q;
    commit_chr_d = commit_chr_q;
    commit_d     = 1'b0;
    del_d        = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    if (key_vld) begin
      if (key_code < NUM_GROUPS) begin
        if (pend_q && group_q == key_code[3:0]) begin
          tap_d = (tap_q == group_size(group_q) - 2'd1) ? 2'd0 : tap_q + 2'd1;
        end else begin
          pend_d  = 1'b1;
          group_d = key_code[3:0];
          tap_d   = 2'd0;
        end
      end else begin
        case (key_code)
          KEY_SUB_LETTER: begin
            if (pend_q && len_q != LEN_W'(MAX_WORD_LEN)) begin
              commit_d     = 1'b1;
              commit_chr_d = pend_chr;
              len_d        = len_q + 1'b1;
              pend_d       = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
          KEY_CLEAR: begin
            if (pend_q) begin
              pend_d = 1'b0;
            end else if (len_q != '0) begin
              del_d = 1'b1;
              len_d = len_q - 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          KEY_SUB_WORD: begin
            if (pend_q || len_q == '0) begin
              err_d = 1'b1;
            end else begin
              done_d = 1'b1;
              len_d  = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pend_q       <= 1'b0;
      group_q      <= '0;
      tap_q        <= '0;
      len_q        <= '0;
      commit_chr_q <= '0;
      commit_q     <= 1'b0;
      del_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      group_q      <= group_d;
      tap_q        <= tap_d;
      len_q        <= len_d;
      commit_chr_q <= commit_chr_d;
      commit_q     <= commit_d;
      del_q        <= del_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign pending_vld = pend_q;
  assign pending_chr = pend_chr;
  assign commit_vld  = commit_q;
  assign commit_chr  = commit_chr_q;
  assign del_pulse   = del_q;
  assign word_done   = done_q;
  assign word_len    = len_q;
  assign key_error   = err_q;

endmodule

// File: tb/tb_keypad_word_entry.sv
// tb/tb_keypad_word_entry.sv - directed and randomized checks of keypad_word_entry against a word-level model
module tb_keypad_word_entry;

  logic       clk = 1'b0;
  logic       nRst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       pending_vld;
  logic [7:0] pending_chr;
  logic       commit_vld;
  logic [7:0] commit_chr;
  logic       del_pulse;
  logic       word_done;
  logic [1:0] word_len;
  logic       key_error;

  int checks = 0;
  int errors = 0;
  int held = -1;
  int n_commit, n_del, n_done, n_err, n_multi;

  byte m_pend;
  byte m_last;
  byte m_word[$];

  keypad_word_entry #(
    .ROWS(4), .COLS(4), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .MAX_WORD_LEN(3)
  ) dut (
    .clk(clk), .nRst(nRst), .row_in(row_in), .col_out(col_out),
    .pending_vld(pending_vld), .pending_chr(pending_chr),
    .commit_vld(commit_vld), .commit_chr(commit_chr),
    .del_pulse(del_pulse), .word_done(word_done),
    .word_len(word_len), .key_error(key_error)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key closes its row only while its column is driven.
  always_comb begin
    row_in = '0;
    if (held >= 0 && col_out[held % 4]) row_in[held / 4] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_commit = 0; n_del = 0; n_done = 0; n_err = 0; n_multi = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_commit += int'(commit_vld);
      n_del    += int'(del_pulse);
      n_done   += int'(word_done);
      n_err    += int'(key_error);
      if (int'(commit_vld) + int'(del_pulse) + int'(word_done) + int'(key_error) > 1) n_multi++;
    end
  endtask

  // Word-level model: 0 none, 1 commit, 2 delete, 3 word done, 4 error.
  function automatic int model_key(input int code);
    int ev = 0;
    if (code <= 8) begin
      byte base = byte'(8'h41 + 3 * code);
      int  size = (code == 8) ? 2 : 3;
      if (m_pend != 0 && m_pend >= base && m_pend < base + size)
        m_pend = byte'(base + ((m_pend - base + 1) % size));
      else
        m_pend = base;
    end else if (code == 10) begin
      if (m_pend != 0 && m_word.size() < 3) begin
        m_word.push_back(m_pend); m_last = m_pend; m_pend = 0; ev = 1;
      end else ev = 4;
    end else if (code == 9) begin
      if (m_pend != 0) m_pend = 0;
      else if (m_word.size() > 0) begin void'(m_word.pop_back()); ev = 2; end
      else ev = 4;
    end else if (code == 11) begin
      if (m_pend != 0 || m_word.size() == 0) ev = 4;
      else begin m_word.delete(); ev = 3; end
    end
    return ev;
  endfunction

  task automatic press_and_check(input int code, input string tag);
    int ev;
    ev = model_key(code);
    clear_counts();
    held = code;
    run_cycles(40);
    held = -1;
    run_cycles(30);
    check({tag, "_commit"}, n_commit, (ev == 1) ? 1 : 0);
    check({tag, "_del"},    n_del,    (ev == 2) ? 1 : 0);
    check({tag, "_done"},   n_done,   (ev == 3) ? 1 : 0);
    check({tag, "_err"},    n_err,    (ev == 4) ? 1 : 0);
    check({tag, "_onepulse"}, n_multi, 0);
    check({tag, "_pvld"},   pending_vld, (m_pend != 0) ? 1 : 0);
    check({tag, "_pchr"},   pending_chr, 8'(m_pend));
    check({tag, "_len"},    word_len,    m_word.size());
    check({tag, "_cchr"},   commit_chr,  8'(m_last));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pvld"}, pending_vld, 0);
    check({tag, "_pchr"}, pending_chr, 0);
    check({tag, "_pulses"}, {commit_vld, del_pulse, word_done, key_error}, 0);
    check({tag, "_cchr"}, commit_chr, 0);
    check({tag, "_len"}, word_len, 0);
  endtask

  initial begin
    logic [3:0] col0;
    int changed;
    m_pend = 0; m_last = 0;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b0001);
    check_idle_outputs("rst");
    nRst = 1'b1;

    // Idle scan: column advances every 4 cycles and wraps.
    repeat (2) @(negedge clk);
    check("scan0", col_out, 4'b0001);
    repeat (4) @(negedge clk);
    check("scan1", col_out, 4'b0010);
    repeat (4) @(negedge clk);
    check("scan2", col_out, 4'b0100);
    repeat (4) @(negedge clk);
    check("scan3", col_out, 4'b1000);
    check_idle_outputs("scan3");
    repeat (4) @(negedge clk);
    check("scan_wrap", col_out, 4'b0001);

    press_and_check(1, "keyD");
    check("keyD_const", pending_chr, 8'h44);
    press_and_check(9, "drop_pend");

    // Bounce shorter than the debounce window.
    held = 5;
    for (int i = 0; i < 40 && !col_out[1]; i++) @(negedge clk);
    check("bounce_colwait", col_out[1], 1);
    clear_counts();
    run_cycles(4);
    held = -1;
    col0 = col_out;
    changed = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycles(1);
      if (col_out != col0) changed = 1;
    end
    check("bounce_pulses", n_commit + n_del + n_done + n_err, 0);
    check("bounce_pvld", pending_vld, 0);
    check("bounce_rescan", changed, 1);

    press_and_check(0, "tap1"); check("tapA", pending_chr, 8'h41);
    press_and_check(0, "tap2"); check("tapB", pending_chr, 8'h42);
    press_and_check(0, "tap3"); check("tapC", pending_chr, 8'h43);
    press_and_check(0, "tap4"); check("tapA2", pending_chr, 8'h41);
    press_and_check(10, "subA"); check("subA_chr", commit_chr, 8'h41);
    check("subA_len", word_len, 1);

    press_and_check(8, "y1"); check("y1c", pending_chr, 8'h59);
    press_and_check(8, "z1"); check("z1c", pending_chr, 8'h5A);
    press_and_check(8, "y2"); check("y2c", pending_chr, 8'h59);
    press_and_check(1, "d2"); check("d2c", pending_chr, 8'h44);
    press_and_check(11, "word_pend_err");

    press_and_check(10, "subD");
    press_and_check(2, "keyG");
    press_and_check(10, "subG"); check("full_len", word_len, 3);
    press_and_check(3, "keyJ");
    press_and_check(10, "sub_full_err"); check("full_len2", word_len, 3);
    press_and_check(9, "clr_pend");
    press_and_check(10, "sub_nopend_err");
    press_and_check(9, "clr_del"); check("del_len", word_len, 2);
    press_and_check(11, "word_done"); check("done_len", word_len, 0);
    press_and_check(11, "word_empty_err");
    press_and_check(9, "clr_empty_err");
    press_and_check(12, "ign12");
    press_and_check(15, "ign15");

    for (int k = 0; k < 24; k++) begin
      press_and_check(int'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
    end

    // Reset while a press is being debounced.
    press_and_check(4, "pre_rst");
    held = 2;
    for (int i = 0; i < 40 && !col_out[2]; i++) @(negedge clk);
    check("rst_colwait", col_out[2], 1);
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    held = -1;
    nRst = 1'b1;
    m_pend = 0; m_last = 0; m_word.delete();
    check("midrst_col", col_out, 4'b0001);
    check_idle_outputs("midrst");
    clear_counts();
    run_cycles(40);
    check("midrst_noevent", n_commit + n_del + n_done + n_err, 0);
    check("midrst_pvld", pending_vld, 0);
    check("midrst_len", word_len, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
